// File: rtl/video_mnist_pkg.sv
// Shared definitions for the MNIST colour-overlay parameter path.
package video_mnist_pkg;

    // Overlay mode encodings driven on param_mode.
    localparam logic [1:0] MODE_OFF   = 2'b00;
    localparam logic [1:0] MODE_NUM   = 2'b01;
    localparam logic [1:0] MODE_COLOR = 2'b10;
    localparam logic [1:0] MODE_BOTH  = 2'b11;

    // Parameter-change sequencer states.
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_PEND  = 2'd1,
        ST_APPLY = 2'd2
    } st_t;

    // Auto-cycle step: next mode in the encoding, wrapping from MODE_BOTH to MODE_OFF.
    function automatic logic [1:0] next_mode(input logic [1:0] mode);
        return mode + 2'd1;
    endfunction

endpackage

// File: rtl/video_frame_tracker.sv
// Observes an AXI-Stream video handshake and tracks line/frame position.
// Produces a combinational frame_end strobe and a wrapping completed-frame count.
module video_frame_tracker #(
    parameter int TUSER_WIDTH = 1,
    parameter int FRAME_LINES = 480,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic [TUSER_WIDTH-1:0] mon_tuser,
    input  logic                   mon_tlast,
    input  logic                   mon_tvalid,
    input  logic                   mon_tready,
    output logic                   frame_end,
    output logic [CNT_WIDTH-1:0]   frame_count
);

    localparam logic [CNT_WIDTH-1:0] LAST_LINE = CNT_WIDTH'(FRAME_LINES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

    logic                 beat;
    logic [CNT_WIDTH-1:0] line_cnt;
    logic [CNT_WIDTH-1:0] line_base;

    // Start-of-frame resync is applied before the end-of-line rule on the same beat.
    // NOTE: every always_comb output is assigned on every path, so no latch can be inferred.
    always_comb begin
        beat      = mon_tvalid & mon_tready;
        line_base = (beat && mon_tuser[0]) ? '0 : line_cnt;
        frame_end = beat & mon_tlast & (line_base == LAST_LINE);
    end

    // Line counter and completed-frame counter.
    // NOTE: reset is synchronous -- aresetn is only sampled on the clock edge.
    // NOTE: state registers use <= so every flop in the design sees pre-edge values.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            line_cnt    <= '0;
            frame_count <= '0;
        end else if (frame_end) begin
            line_cnt    <= '0;
            frame_count <= frame_count + CNT_ONE;
        end else if (beat && mon_tlast) begin
            line_cnt    <= line_base + CNT_ONE;
        end else begin
            line_cnt    <= line_base;
        end
    end

endmodule

// File: rtl/video_mnist_color_param_sequencer.sv
// Frame-synchronous commit of mode/threshold parameters for the MNIST colour overlay.
// Host requests and an auto-cycle timer share one pending slot; changes land only
// between frames so a frame never mixes two parameter sets.
module video_mnist_color_param_sequencer
    import video_mnist_pkg::*;
#(
    parameter int         TUSER_WIDTH  = 1,
    parameter int         TCOUNT_WIDTH = 4,
    parameter int         FRAME_LINES  = 480,
    parameter int         CNT_WIDTH    = 16,
    parameter logic [1:0] INIT_MODE    = MODE_COLOR,
    parameter int         INIT_TH      = 5
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    auto_enable,
    input  logic [CNT_WIDTH-1:0]    auto_frames,
    input  logic [1:0]              s_param_mode,
    input  logic [TCOUNT_WIDTH-1:0] s_param_th,
    input  logic                    s_param_valid,
    output logic                    s_param_ready,
    input  logic [TUSER_WIDTH-1:0]  mon_tuser,
    input  logic                    mon_tlast,
    input  logic                    mon_tvalid,
    input  logic                    mon_tready,
    output logic [1:0]              param_mode,
    output logic [TCOUNT_WIDTH-1:0] param_th,
    output logic                    param_update,
    output logic [CNT_WIDTH-1:0]    frame_count,
    output logic                    busy
);

    localparam logic [TCOUNT_WIDTH-1:0] INIT_TH_W = TCOUNT_WIDTH'(INIT_TH);
    localparam logic [CNT_WIDTH-1:0]    CNT_ONE   = CNT_WIDTH'(1);

    logic                    frame_end;
    logic                    auto_armed;
    logic                    auto_hit;
    logic                    auto_req;
    logic                    host_fire;
    logic [CNT_WIDTH-1:0]    auto_cnt;
    st_t                     state;
    logic [1:0]              pend_mode;
    logic [TCOUNT_WIDTH-1:0] pend_th;

    video_frame_tracker #(
        .TUSER_WIDTH (TUSER_WIDTH),
        .FRAME_LINES (FRAME_LINES),
        .CNT_WIDTH   (CNT_WIDTH)
    ) u_tracker (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .mon_tuser   (mon_tuser),
        .mon_tlast   (mon_tlast),
        .mon_tvalid  (mon_tvalid),
        .mon_tready  (mon_tready),
        .frame_end   (frame_end),
        .frame_count (frame_count)
    );

    // Request sources: host handshake and auto-timer expiry on a frame boundary.
    always_comb begin
        auto_armed = auto_enable && (auto_frames != '0);
        auto_hit   = (auto_cnt == auto_frames - CNT_ONE);
        auto_req   = auto_armed && frame_end && auto_hit;
        host_fire  = s_param_valid && s_param_ready;
    end

    // Auto timer: counts frame ends, restarting after each step or when disabled.
    always_ff @(posedge aclk) begin
        if (!aresetn || !auto_enable) begin
            auto_cnt <= '0;
        end else if (auto_armed && frame_end) begin
            auto_cnt <= auto_hit ? '0 : auto_cnt + CNT_ONE;
        end
    end

    // Sequencer FSM with registered ready/busy/update and committed parameters.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state         <= ST_RUN;
            pend_mode     <= INIT_MODE;
            pend_th       <= INIT_TH_W;
            param_mode    <= INIT_MODE;
            param_th      <= INIT_TH_W;
            param_update  <= 1'b0;
            s_param_ready <= 1'b0;
            busy          <= 1'b0;
        end else begin
            param_update <= 1'b0;
            case (state)
                ST_RUN: begin
                    s_param_ready <= 1'b1;
                    // Host has priority; a coincident auto step is dropped, not queued.
                    if (host_fire) begin
                        pend_mode     <= s_param_mode;
                        pend_th       <= s_param_th;
                        state         <= ST_PEND;
                        s_param_ready <= 1'b0;
                        busy          <= 1'b1;
                    end else if (auto_req) begin
                        pend_mode     <= next_mode(param_mode);
                        pend_th       <= param_th;
                        state         <= ST_PEND;
                        s_param_ready <= 1'b0;
                        busy          <= 1'b1;
                    end
                end
                ST_PEND: begin
                    if (frame_end) begin
                        state <= ST_APPLY;
                    end
                end
                ST_APPLY: begin
                    param_mode    <= pend_mode;
                    param_th      <= pend_th;
                    param_update  <= 1'b1;
                    state         <= ST_RUN;
                    s_param_ready <= 1'b1;
                    busy          <= 1'b0;
                end
                default: begin
                    state         <= ST_RUN;
                    s_param_ready <= 1'b1;
                    busy          <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_video_mnist_color_param_sequencer.sv
// Self-checking bench for video_mnist_color_param_sequencer with FRAME_LINES=4.
// Cycle table for the basic host commit, hand sequences for the multi-cycle cases,
// and a commit scoreboard that every param_update pulse is checked against.
module tb_video_mnist_color_param_sequencer;

    localparam int TW = 4;
    localparam int CW = 16;
    localparam int FL = 4;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic          auto_enable = 1'b0;
    logic [CW-1:0] auto_frames = '0;
    logic [1:0]    s_param_mode = '0;
    logic [TW-1:0] s_param_th = '0;
    logic          s_param_valid = 1'b0;
    logic          s_param_ready;
    logic [0:0]    mon_tuser = '0;
    logic          mon_tlast = 1'b0;
    logic          mon_tvalid = 1'b0;
    logic          mon_tready = 1'b0;
    logic [1:0]    param_mode;
    logic [TW-1:0] param_th;
    logic          param_update;
    logic [CW-1:0] frame_count;
    logic          busy;

    video_mnist_color_param_sequencer #(
        .TUSER_WIDTH  (1),
        .TCOUNT_WIDTH (TW),
        .FRAME_LINES  (FL),
        .CNT_WIDTH    (CW),
        .INIT_MODE    (2'b10),
        .INIT_TH      (5)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .auto_enable   (auto_enable),
        .auto_frames   (auto_frames),
        .s_param_mode  (s_param_mode),
        .s_param_th    (s_param_th),
        .s_param_valid (s_param_valid),
        .s_param_ready (s_param_ready),
        .mon_tuser     (mon_tuser),
        .mon_tlast     (mon_tlast),
        .mon_tvalid    (mon_tvalid),
        .mon_tready    (mon_tready),
        .param_mode    (param_mode),
        .param_th      (param_th),
        .param_update  (param_update),
        .frame_count   (frame_count),
        .busy          (busy)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic          valid;
        logic          tready;
        logic          tuser;
        logic          tlast;
        logic          s_valid;
        logic [1:0]    s_mode;
        logic [TW-1:0] s_th;
        logic          exp_ready;
        logic          exp_busy;
        logic          exp_update;
        logic [1:0]    exp_mode;
        logic [TW-1:0] exp_th;
        logic [CW-1:0] exp_fc;
    } vec_t;

    typedef struct {
        logic [1:0]    mode;
        logic [TW-1:0] th;
    } commit_t;

    commit_t exp_q[$];
    int      n_vec = 0;
    int      n_err = 0;
    int      model_line = 0;
    int      model_fc = 0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    // One accepted video beat; the bench keeps its own line/frame position.
    task automatic send_beat(input logic tu, input logic tl);
        mon_tvalid = 1'b1;
        mon_tready = 1'b1;
        mon_tuser  = tu;
        mon_tlast  = tl;
        if (tu) model_line = 0;
        if (tl) begin
            if (model_line == FL - 1) begin
                model_line = 0;
                model_fc++;
            end else begin
                model_line++;
            end
        end
        step();
        mon_tvalid = 1'b0;
        mon_tuser  = 1'b0;
        mon_tlast  = 1'b0;
    endtask

    // A full frame: start-of-frame beat followed by FL end-of-line beats.
    task automatic send_frame();
        send_beat(1'b1, 1'b0);
        for (int i = 0; i < FL; i++) send_beat(1'b0, 1'b1);
    endtask

    // Scoreboard: each commit pulse must match the oldest expected commit.
    always @(negedge aclk) begin
        if (param_update) begin
            if (exp_q.size() == 0) begin
                check("unexpected_commit", 1, 0);
            end else begin
                commit_t c;
                c = exp_q.pop_front();
                check("commit_mode", int'(param_mode), int'(c.mode));
                check("commit_th", int'(param_th), int'(c.th));
            end
        end
    end

    initial begin
        vec_t tbl[9];
        logic model_ready;
        int   fc0;

        // ---------------- reset ----------------
        aresetn = 1'b0;
        step();
        step();
        check("rst_ready", s_param_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_update", param_update, 0);
        check("rst_mode", param_mode, 2);
        check("rst_th", param_th, 5);
        check("rst_fc", frame_count, 0);
        aresetn = 1'b1;
        step();
        check("ready_after_rst", s_param_ready, 1);

        // ---------------- host commit, cycle table ----------------
        //             vld  trdy tuser tlast sval smode th     rdy  busy upd  mode  th     fc
        tbl[0] = '{1'b1,1'b1,1'b1,1'b0, 1'b0,2'd0,4'd0, 1'b1,1'b0,1'b0,2'd2,4'd5,16'd0};
        tbl[1] = '{1'b1,1'b1,1'b0,1'b1, 1'b0,2'd0,4'd0, 1'b1,1'b0,1'b0,2'd2,4'd5,16'd0};
        tbl[2] = '{1'b0,1'b0,1'b0,1'b0, 1'b1,2'd1,4'd7, 1'b0,1'b1,1'b0,2'd2,4'd5,16'd0};
        tbl[3] = '{1'b1,1'b1,1'b0,1'b1, 1'b0,2'd0,4'd0, 1'b0,1'b1,1'b0,2'd2,4'd5,16'd0};
        tbl[4] = '{1'b1,1'b1,1'b0,1'b1, 1'b0,2'd0,4'd0, 1'b0,1'b1,1'b0,2'd2,4'd5,16'd0};
        tbl[5] = '{1'b1,1'b0,1'b0,1'b1, 1'b0,2'd0,4'd0, 1'b0,1'b1,1'b0,2'd2,4'd5,16'd0};
        tbl[6] = '{1'b1,1'b1,1'b0,1'b1, 1'b0,2'd0,4'd0, 1'b0,1'b1,1'b0,2'd2,4'd5,16'd1};
        tbl[7] = '{1'b0,1'b0,1'b0,1'b0, 1'b0,2'd0,4'd0, 1'b1,1'b0,1'b1,2'd1,4'd7,16'd1};
        tbl[8] = '{1'b0,1'b0,1'b0,1'b0, 1'b0,2'd0,4'd0, 1'b1,1'b0,1'b0,2'd1,4'd7,16'd1};
        model_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            mon_tvalid    = tbl[i].valid;
            mon_tready    = tbl[i].tready;
            mon_tuser     = tbl[i].tuser;
            mon_tlast     = tbl[i].tlast;
            s_param_valid = tbl[i].s_valid;
            s_param_mode  = tbl[i].s_mode;
            s_param_th    = tbl[i].s_th;
            if (tbl[i].s_valid && model_ready) exp_q.push_back('{tbl[i].s_mode, tbl[i].s_th});
            step();
            check($sformatf("v%0d_ready", i), s_param_ready, tbl[i].exp_ready);
            check($sformatf("v%0d_busy", i), busy, tbl[i].exp_busy);
            check($sformatf("v%0d_update", i), param_update, tbl[i].exp_update);
            check($sformatf("v%0d_mode", i), param_mode, tbl[i].exp_mode);
            check($sformatf("v%0d_th", i), param_th, tbl[i].exp_th);
            check($sformatf("v%0d_fc", i), frame_count, tbl[i].exp_fc);
            model_ready = tbl[i].exp_ready;
        end
        mon_tvalid = 1'b0;
        mon_tready = 1'b0;
        mon_tlast  = 1'b0;
        mon_tuser  = 1'b0;
        model_line = 0;
        model_fc   = 1;

        // ---------------- host valid held while busy ----------------
        s_param_valid = 1'b1;
        s_param_mode  = 2'd0;
        s_param_th    = 4'd3;
        exp_q.push_back('{2'd0, 4'd3});
        step();
        check("hold_busy", busy, 1);
        s_param_mode = 2'd3;
        s_param_th   = 4'd9;
        send_beat(1'b1, 1'b0);
        for (int i = 0; i < FL; i++) begin
            send_beat(1'b0, 1'b1);
            check("hold_ready_low", s_param_ready, 0);
        end
        check("hold_no_early_update", param_update, 0);
        step();
        check("hold_update", param_update, 1);
        check("hold_ready_back", s_param_ready, 1);
        exp_q.push_back('{2'd3, 4'd9});
        step();
        s_param_valid = 1'b0;
        check("hold_second_accepted", busy, 1);
        check("hold_second_ready", s_param_ready, 0);
        send_frame();
        step();
        step();
        check("hold_final_mode", param_mode, 3);
        check("hold_final_th", param_th, 9);

        // ---------------- auto cycling from INIT_MODE ----------------
        aresetn = 1'b0;
        step();
        aresetn = 1'b1;
        step();
        model_line = 0;
        model_fc   = 0;
        check("auto_start_mode", param_mode, 2);
        auto_enable = 1'b1;
        auto_frames = 16'd2;
        exp_q.push_back('{2'd3, 4'd5});
        exp_q.push_back('{2'd0, 4'd5});
        exp_q.push_back('{2'd1, 4'd5});
        for (int f = 0; f < 7; f++) send_frame();
        auto_enable = 1'b0;
        step();
        step();
        check("auto_fc", frame_count, model_fc);
        check("auto_mode", param_mode, 1);
        check("auto_all_commits", exp_q.size(), 0);

        // ---------------- host and auto in the same cycle ----------------
        auto_enable = 1'b1;
        auto_frames = 16'd1;
        send_beat(1'b1, 1'b0);
        for (int i = 0; i < FL - 1; i++) send_beat(1'b0, 1'b1);
        s_param_valid = 1'b1;
        s_param_mode  = 2'd2;
        s_param_th    = 4'd4;
        exp_q.push_back('{2'd2, 4'd4});
        send_beat(1'b0, 1'b1);
        s_param_valid = 1'b0;
        check("race_busy", busy, 1);
        send_frame();
        auto_enable = 1'b0;
        step();
        step();
        check("race_mode", param_mode, 2);
        check("race_th", param_th, 4);
        send_frame();
        step();
        step();
        check("race_no_auto_mode", param_mode, 2);
        check("race_no_auto_busy", busy, 0);

        // ---------------- tuser resync ----------------
        fc0 = model_fc;
        send_beat(1'b0, 1'b1);
        send_beat(1'b0, 1'b1);
        send_beat(1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            send_beat(1'b0, 1'b1);
            check("resync_no_frame_end", frame_count, fc0);
        end
        send_beat(1'b0, 1'b1);
        check("resync_frame_end", frame_count, fc0 + 1);
        send_beat(1'b0, 1'b1);
        send_beat(1'b0, 1'b1);
        send_beat(1'b1, 1'b1);
        send_beat(1'b0, 1'b1);
        send_beat(1'b0, 1'b1);
        check("sof_eol_no_frame_end", frame_count, fc0 + 1);
        send_beat(1'b0, 1'b1);
        check("sof_eol_frame_end", frame_count, fc0 + 2);
        check("model_fc", frame_count, model_fc);

        // ---------------- reset while pending ----------------
        s_param_valid = 1'b1;
        s_param_mode  = 2'd1;
        s_param_th    = 4'd2;
        step();
        s_param_valid = 1'b0;
        check("pend_busy", busy, 1);
        send_beat(1'b1, 1'b0);
        send_beat(1'b0, 1'b1);
        aresetn = 1'b0;
        step();
        check("pend_rst_update", param_update, 0);
        check("pend_rst_mode", param_mode, 2);
        check("pend_rst_th", param_th, 5);
        check("pend_rst_fc", frame_count, 0);
        check("pend_rst_busy", busy, 0);
        check("pend_rst_ready", s_param_ready, 0);
        aresetn = 1'b1;
        step();
        model_line = 0;
        model_fc   = 0;
        send_frame();
        step();
        step();
        check("pend_lost_mode", param_mode, 2);
        check("pend_lost_fc", frame_count, 1);
        check("pend_lost_busy", busy, 0);

        check("queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
